mc14500_core_sync: RTL and testbench

Parametrised, single-clock successor to the four-stage handshake ring around the MC14500B-style ICU. It integrates program memory, program counter, ICU, I/O block and a new scratch-bit RAM under one FETCH/EXEC state machine. It adds a return stack for JMP/RTN, run/single-step control, and a halted-only program-load port. It sits at the system top, between the UART program loader and the board I/O pins.

---
 rtl/mc14500_core_sync.sv | 204 ++++++++++++++++++++
 tb/tb_mc14500_core_sync.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc14500_core_sync.sv
// mc14500_core_sync: single-clock MC14500B-style ICU with program memory,
// scratch bits, output latches, return stack and run/single-step control.
module mc14500_core_sync #(
  parameter int ADDR_WIDTH        = 8,
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
  parameter int INPUT_SIZE        = 5,
  parameter int OUTPUT_SIZE       = 5,
  parameter int SCRATCH_SIZE      = 8,
  parameter int STACK_DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   step,
  input  logic                   program_write,
  input  logic [ADDR_WIDTH-1:0]  program_addr,
  input  logic [DATA_WIDTH-1:0]  program_cmd,
  input  logic [INPUT_SIZE-1:0]  input_pins,
  output logic [OUTPUT_SIZE-1:0] output_pins,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   halted,
  output logic                   flag_o,
  output logic                   flag_f,
  output logic                   stack_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_e;

  typedef enum logic [3:0] {
    OP_NOPO, OP_LD, OP_LDC, OP_AND, OP_ANDC, OP_OR, OP_ORC, OP_XNOR,
    OP_STO, OP_STOC, OP_IEN, OP_OEN, OP_JMP, OP_RTN, OP_SKZ, OP_NOPF
  } op_e;

  localparam int SCR_BASE = INPUT_SIZE;
  localparam int OUT_BASE = INPUT_SIZE + SCRATCH_SIZE;
  localparam int SP_W     = $clog2(STACK_DEPTH + 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d, pc_inc, operand;
  logic                    rr_q, rr_d, ien_q, ien_d, oen_q, oen_d;
  logic                    skip_q, skip_d;
  logic                    flag_o_q, flag_o_d, flag_f_q, flag_f_d;
  logic                    ovf_q, ovf_d;
  logic [OUTPUT_SIZE-1:0]  out_q, out_d;
  logic [SCRATCH_SIZE-1:0] scratch_q, scratch_d;
  logic [ADDR_WIDTH-1:0]   stack_q [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0]   stack_d [STACK_DEPTH];
  logic [SP_W-1:0]         sp_q, sp_d;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0]   instr_q;
  op_e                     op;
  logic [31:0]             addr_ext;
  logic                    raw_bit, data_bit, wr_en, wr_bit;

  assign op       = op_e'(instr_q[DATA_WIDTH-1 -: INSTRUCTION_WIDTH]);
  assign operand  = instr_q[ADDR_WIDTH-1:0];
  assign addr_ext = 32'(operand);
  assign pc_inc   = pc_q + ADDR_WIDTH'(1);

  assign output_pins    = out_q;
  assign pc             = pc_q;
  assign halted         = (state_q == S_IDLE);
  assign flag_o         = flag_o_q;
  assign flag_f         = flag_f_q;
  assign stack_overflow = ovf_q;

  // Operand read decode: inputs, scratch, output readback, RR; gated by IEN.
  always_comb begin
    raw_bit = 1'b0;
    for (int i = 0; i < INPUT_SIZE; i++)
      if (addr_ext == 32'(i)) raw_bit = input_pins[i];
    for (int i = 0; i < SCRATCH_SIZE; i++)
      if (addr_ext == 32'(SCR_BASE + i)) raw_bit = scratch_q[i];
    for (int i = 0; i < OUTPUT_SIZE; i++)
      if (addr_ext == 32'(OUT_BASE + i)) raw_bit = out_q[i];
    if (operand == '1) raw_bit = rr_q;
    data_bit = ien_q & raw_bit;
  end

  // Sequencer and instruction execution: all architectural updates happen on the EXEC edge.
  always_comb begin
    // NOTE: every variable gets its hold/default value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    pc_d      = pc_q;
    rr_d      = rr_q;
    ien_d     = ien_q;
    oen_d     = oen_q;
    skip_d    = skip_q;
    out_d     = out_q;
    scratch_d = scratch_q;
    stack_d   = stack_q;
    sp_d      = sp_q;
    ovf_d     = ovf_q;
    flag_o_d  = 1'b0;
    flag_f_d  = 1'b0;
    wr_en     = 1'b0;
    wr_bit    = 1'b0;

    case (state_q)
      S_IDLE:  if (run || step) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d = run ? S_FETCH : S_IDLE;
        pc_d    = pc_inc;
        skip_d  = 1'b0;
        if (!skip_q) begin
          case (op)
            OP_NOPO: flag_o_d = 1'b1;
            OP_LD:   rr_d = data_bit;
            OP_LDC:  rr_d = ~data_bit;
            OP_AND:  rr_d = rr_q & data_bit;
            OP_ANDC: rr_d = rr_q & ~data_bit;
            OP_OR:   rr_d = rr_q | data_bit;
            OP_ORC:  rr_d = rr_q | ~data_bit;
            OP_XNOR: rr_d = ~(rr_q ^ data_bit);
            OP_STO: begin
              wr_en  = oen_q;
              wr_bit = rr_q;
            end
            OP_STOC: begin
              wr_en  = oen_q;
              wr_bit = ~rr_q;
            end
            OP_IEN:  ien_d = data_bit;
            OP_OEN:  oen_d = data_bit;
            OP_JMP: begin
              pc_d = operand;
              if (sp_q == SP_W'(STACK_DEPTH)) begin
                // Full: drop the oldest return address to make room.
                for (int i = 0; i < STACK_DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
                stack_d[STACK_DEPTH-1] = pc_inc;
                ovf_d = 1'b1;
              end else begin
                for (int i = 0; i < STACK_DEPTH; i++)
                  if (sp_q == SP_W'(i)) stack_d[i] = pc_inc;
                sp_d = sp_q + SP_W'(1);
              end
            end
            OP_RTN: begin
              if (sp_q != '0) begin
                for (int i = 0; i < STACK_DEPTH; i++)
                  if (sp_q == SP_W'(i + 1)) pc_d = stack_q[i];
                sp_d = sp_q - SP_W'(1);
              end
            end
            OP_SKZ:  skip_d = ~rr_q;
            OP_NOPF: flag_f_d = 1'b1;
            default: ;
          endcase
        end
        if (wr_en) begin
          for (int i = 0; i < SCRATCH_SIZE; i++)
            if (addr_ext == 32'(SCR_BASE + i)) scratch_d[i] = wr_bit;
          for (int i = 0; i < OUTPUT_SIZE; i++)
            if (addr_ext == 32'(OUT_BASE + i)) out_d[i] = wr_bit;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Program memory: load port writes while halted, FETCH registers mem[pc].
  always_ff @(posedge clk) begin
    // NOTE: the array and its read register have no reset so they map onto RAM; contents survive reset.
    if (program_write && state_q == S_IDLE) mem[program_addr] <= program_cmd;
    if (state_q == S_FETCH) instr_q <= mem[pc_q];
  end

  // Architectural state registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      rr_q      <= 1'b0;
      ien_q     <= 1'b1;
      oen_q     <= 1'b1;
      skip_q    <= 1'b0;
      out_q     <= '0;
      scratch_q <= '0;
      sp_q      <= '0;
      ovf_q     <= 1'b0;
      flag_o_q  <= 1'b0;
      flag_f_q  <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rr_q      <= rr_d;
      ien_q     <= ien_d;
      oen_q     <= oen_d;
      skip_q    <= skip_d;
      out_q     <= out_d;
      scratch_q <= scratch_d;
      sp_q      <= sp_d;
      ovf_q     <= ovf_d;
      flag_o_q  <= flag_o_d;
      flag_f_q  <= flag_f_d;
      stack_q   <= stack_d;
    end
  end

endmodule

// File: tb/tb_mc14500_core_sync.sv
// tb_mc14500_core_sync: directed programs with an instruction-level model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_mc14500_core_sync;

  localparam logic [3:0] NOPO = 4'h0, LD = 4'h1, LDC = 4'h2, AND = 4'h3,
                         ANDC = 4'h4, OR = 4'h5, ORC = 4'h6, XNOR = 4'h7,
                         STO = 4'h8, STOC = 4'h9, IEN = 4'hA, OEN = 4'hB,
                         JMP = 4'hC, RTN = 4'hD, SKZ = 4'hE, NOPF = 4'hF;

  logic        clk;
  logic        reset;
  logic        run, step, program_write;
  logic [7:0]  program_addr;
  logic [11:0] program_cmd;
  logic [4:0]  input_pins;
  logic [4:0]  output_pins;
  logic [7:0]  pc;
  logic        halted, flag_o, flag_f, stack_overflow;

  int n_vec  = 0;
  int n_miss = 0;
  bit cmp_en = 0;

  mc14500_core_sync dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .program_write(program_write), .program_addr(program_addr),
    .program_cmd(program_cmd), .input_pins(input_pins),
    .output_pins(output_pins), .pc(pc), .halted(halted),
    .flag_o(flag_o), .flag_f(flag_f), .stack_overflow(stack_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  logic [11:0] m_mem [256];
  int          m_busy = 0;        // edges left until the current instruction retires
  logic [7:0]  m_pc;
  logic        m_rr, m_ien, m_oen, m_skip, m_fo, m_ff, m_ovf;
  logic [4:0]  m_out;
  logic [7:0]  m_scr;
  logic [7:0]  m_stack [$];

  function automatic logic m_read(input int a);
    if (!m_ien) return 1'b0;
    if (a < 5)   return input_pins[a];
    if (a < 13)  return m_scr[a-5];
    if (a < 18)  return m_out[a-13];
    if (a == 255) return m_rr;
    return 1'b0;
  endfunction

  task automatic m_store(input int a, input logic v);
    if (a >= 5 && a < 13)       m_scr[a-5] = v;
    else if (a >= 13 && a < 18) m_out[a-13] = v;
  endtask

  task automatic m_reset();
    m_busy = 0; m_pc = 8'd0; m_rr = 1'b0; m_ien = 1'b1; m_oen = 1'b1;
    m_skip = 1'b0; m_fo = 1'b0; m_ff = 1'b0; m_ovf = 1'b0;
    m_out = 5'd0; m_scr = 8'd0; m_stack.delete();
  endtask

  task automatic m_retire();
    logic [11:0] w;
    int          op, a;
    logic        d;
    logic [7:0]  nxt;
    w   = m_mem[m_pc];
    op  = int'(w[11:8]);
    a   = int'(w[7:0]);
    d   = m_read(a);
    nxt = m_pc + 8'd1;
    m_pc = nxt;
    if (m_skip) begin
      m_skip = 1'b0;
      return;
    end
    case (op)
      0:  m_fo = 1'b1;
      1:  m_rr = d;
      2:  m_rr = !d;
      3:  m_rr = m_rr && d;
      4:  m_rr = m_rr && !d;
      5:  m_rr = m_rr || d;
      6:  m_rr = m_rr || !d;
      7:  m_rr = (m_rr == d);
      8:  if (m_oen) m_store(a, m_rr);
      9:  if (m_oen) m_store(a, !m_rr);
      10: m_ien = d;
      11: m_oen = d;
      12: begin
        m_stack.push_back(nxt);
        if (m_stack.size() > 4) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
        m_pc = w[7:0];
      end
      13: if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      14: m_skip = (m_rr == 1'b0);
      default: m_ff = 1'b1;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_reset();
    else begin
      m_fo = 1'b0;
      m_ff = 1'b0;
      if (m_busy == 0) begin
        if (program_write) m_mem[program_addr] = program_cmd;
        if (run || step) m_busy = 2;
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_retire();
          if (run) m_busy = 2;
        end
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("output_pins", 32'(output_pins), 32'(m_out));
      check("pc", 32'(pc), 32'(m_pc));
      check("halted", 32'(halted), 32'(m_busy == 0));
      check("flag_o", 32'(flag_o), 32'(m_fo));
      check("flag_f", 32'(flag_f), 32'(m_ff));
      check("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [11:0] ins(input logic [3:0] op, input int a);
    logic [31:0] av;
    av = a;
    return {op, av[7:0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input int a, input logic [11:0] w);
    logic [31:0] av;
    av = a;
    program_write = 1'b1;
    program_addr  = av[7:0];
    program_cmd   = w;
    tick(1);
    program_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      tick(1);
    end
    check("halt_within_budget", 32'(halted), 32'd1);
  endtask

  task automatic step_n(input int n);
    repeat (n) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      wait_halt(8);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, seen_f, seen_o;
    reset = 1'b1; run = 1'b0; step = 1'b0; program_write = 1'b0;
    program_addr = 8'd0; program_cmd = 12'd0; input_pins = 5'd0;
    tick(2);
    reset = 1'b0;
    cmp_en = 1'b1;
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_halted", 32'(halted), 32'd1);
    check("reset_outputs", 32'(output_pins), 32'd0);
    check("reset_overflow", 32'(stack_overflow), 32'd0);

    for (int a = 0; a < 256; a++) wr(a, ins(NOPO, 0));

    // LD 0 / STO 13 / JMP 0 free-running
    wr(0, ins(LD, 0)); wr(1, ins(STO, 13)); wr(2, ins(JMP, 0));
    input_pins = 5'b00001;
    run = 1'b1;
    tick(3); check("loop_pc_after_ld", 32'(pc), 32'd1);
    tick(2); check("loop_pc_after_sto", 32'(pc), 32'd2);
    check("loop_out0_set", 32'(output_pins), 32'd1);
    tick(2); check("loop_pc_after_jmp", 32'(pc), 32'd0);
    run = 1'b0;
    wait_halt(8);

    // SKZ with RR=0 suppresses STOC
    do_reset();
    wr(0, ins(LD, 5)); wr(1, ins(SKZ, 0)); wr(2, ins(STOC, 13)); wr(3, ins(NOPF, 0));
    step_n(3);
    check("skz_pc_past_skipped", 32'(pc), 32'd3);
    check("skz_no_store", 32'(output_pins), 32'd0);
    step_n(1);

    // Gating, logic ops, scratch, readback, unmapped/input writes
    do_reset();
    input_pins = 5'b10110;
    wr(0, ins(OEN, 5));   wr(1, ins(STOC, 13)); wr(2, ins(ORC, 5));   wr(3, ins(OEN, 255));
    wr(4, ins(LDC, 255)); wr(5, ins(STOC, 13)); wr(6, ins(LD, 0));    wr(7, ins(XNOR, 6));
    wr(8, ins(STO, 14));  wr(9, ins(AND, 4));   wr(10, ins(ANDC, 1)); wr(11, ins(STOC, 15));
    wr(12, ins(ORC, 5));  wr(13, ins(STO, 7));  wr(14, ins(LD, 7));   wr(15, ins(STO, 0));
    wr(16, ins(STO, 100)); wr(17, ins(LDC, 7)); wr(18, ins(OR, 7));   wr(19, ins(STO, 16));
    wr(20, ins(LD, 13));  wr(21, ins(STOC, 17)); wr(22, ins(IEN, 5)); wr(23, ins(LD, 7));
    wr(24, ins(STOC, 17)); wr(25, ins(LDC, 255)); wr(26, ins(STO, 14)); wr(27, ins(NOPF, 0));
    step_n(2);  check("oen0_blocks_stoc", 32'(output_pins), 32'd0);
    step_n(4);  check("oen1_allows_stoc", 32'(output_pins), 32'b00001);
    step_n(16); check("logic_ops_outputs", 32'(output_pins), 32'b01111);
    step_n(6);  check("ien0_gated_reads", 32'(output_pins), 32'b11111);
    check("prog_b_end_pc", 32'(pc), 32'd28);

    // Nested JMPs overflow the 4-deep stack, then unwind
    do_reset();
    wr(0, ins(JMP, 10));  wr(10, ins(JMP, 20)); wr(20, ins(JMP, 30));
    wr(30, ins(JMP, 40)); wr(40, ins(JMP, 50)); wr(50, ins(RTN, 0));
    wr(41, ins(RTN, 0));  wr(31, ins(RTN, 0));  wr(21, ins(RTN, 0));
    wr(11, ins(RTN, 0));  wr(12, ins(NOPF, 0));
    step_n(4); check("no_overflow_at_4", 32'(stack_overflow), 32'd0);
    step_n(1); check("overflow_at_5", 32'(stack_overflow), 32'd1);
    check("pc_after_5_jmps", 32'(pc), 32'd50);
    step_n(1); check("rtn1_pc", 32'(pc), 32'd41);
    step_n(1); check("rtn2_pc", 32'(pc), 32'd31);
    step_n(1); check("rtn3_pc", 32'(pc), 32'd21);
    step_n(1); check("rtn4_pc", 32'(pc), 32'd11);
    step_n(1); check("rtn_empty_pc", 32'(pc), 32'd12);

    // PC wraps from 255 to 0
    do_reset();
    wr(0, ins(JMP, 255)); wr(255, ins(LD, 0));
    step_n(1); check("jmp_to_top", 32'(pc), 32'd255);
    step_n(1); check("pc_wrap", 32'(pc), 32'd0);

    // Single-step busy time and program_write ignored while running
    do_reset();
    wr(0, ins(NOPF, 0)); wr(1, ins(JMP, 0));
    busy_cnt = 0;
    step = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      step = 1'b0;
      if (!halted) busy_cnt++;
    end
    check("step_busy_cycles", 32'(busy_cnt), 32'd2);
    run = 1'b1;
    tick(3);
    step = 1'b1;
    wr(0, ins(NOPO, 0));
    step = 1'b0;
    tick(4);
    run = 1'b0;
    wait_halt(8);
    do_reset();
    seen_f = 0; seen_o = 0;
    step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      step = 1'b0;
      if (flag_f) seen_f++;
      if (flag_o) seen_o++;
    end
    check("readback_flag_f", 32'(seen_f), 32'd1);
    check("readback_flag_o", 32'(seen_o), 32'd0);

    // Reset during EXEC of STO aborts the store
    do_reset();
    wr(0, ins(ORC, 5)); wr(1, ins(STO, 13));
    step_n(1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(1);
    reset = 1'b1;
    #1;
    check("async_reset_pc", 32'(pc), 32'd0);
    check("async_reset_halted", 32'(halted), 32'd1);
    tick(1);
    reset = 1'b0;
    check("aborted_store_out", 32'(output_pins), 32'd0);
    wr(0, ins(STO, 13));
    step_n(1);
    check("rr_cleared_by_reset", 32'(output_pins), 32'd0);
    check("pc_after_post_reset_step", 32'(pc), 32'd1);

    tick(2);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
